mdu_iterative: RTL and testbench

// - Iterative RV32M multiply/divide unit; consumes the two register-file read operands (rs1/rs2 data)
//   and produces a result plus destination index for the register-file write port (data/addr/write-enable).
// - Sits beside the ALU; control stalls the PC while busy=1 and steers wb_en/rd_out/result into the write port.
// - One shift/add (multiply) or shift/subtract (divide) step per cycle; fixed latency, no early exit.

---
 rtl/mdu_pkg.sv | 34 +++
 rtl/mdu_negate.sv | 15 +
 rtl/mdu_iterative.sv | 175 +++++++++++++++++
 tb/tb_mdu_iterative.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide unit.
//   mdu_op_e    : funct3 encodings of the M-extension operations
//   mdu_state_e : sequencer states
//   DIV0_Q      : quotient returned on divide-by-zero
//   OVF_Q       : quotient returned on signed overflow (most-negative / -1)
package mdu_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    CALC  = 2'd2,
    DONE  = 2'd3
  } mdu_state_e;

  localparam logic [31:0] DIV0_Q = '1;
  localparam logic [31:0] OVF_Q  = 32'h8000_0000;

  // funct3[2] separates the divide class from the multiply class.
  function automatic logic op_is_div(input mdu_op_e op);
    return op[2];
  endfunction

endpackage

// File: rtl/mdu_negate.sv
// Conditional two's-complement.
//   en : 1 -> y = -a, 0 -> y = a
//   a  : W-bit input
//   y  : W-bit output
module mdu_negate #(
  parameter int W = 32
) (
  input  logic         en,
  input  logic [W-1:0] a,
  output logic [W-1:0] y
);

  assign y = en ? ((~a) + W'(1)) : a;

endmodule

// File: rtl/mdu_iterative.sv
// Iterative RV32M multiply/divide unit. One shift-add (multiply) or
// restoring shift-subtract (divide) step per cycle, fixed latency.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : request, sampled in IDLE/DONE only
//   kill       : synchronous abort, wins over start
//   funct3     : operation select (mdu_op_e)
//   op_a, op_b : rs1 / rs2 operands
//   rd_in      : destination register index
//   busy       : operation in flight (SETUP/CALC)
//   done       : one-cycle pulse, result/rd_out valid
//   wb_en      : done with a non-zero destination
//   rd_out     : destination of the completed operation
//   result     : completed value, held until the next completion
module mdu_iterative
  import mdu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            kill,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            done,
  output logic            wb_en,
  output logic [4:0]      rd_out,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);

  mdu_state_e        state, state_nxt;
  mdu_op_e           op_q;
  logic [XLEN-1:0]   a_q, b_q;       // raw operands latched on accept
  logic [XLEN-1:0]   ma_q, mb_q;     // operand magnitudes
  logic [4:0]        rd_q;
  logic              sa_q, sb_q, div0_q, ovf_q;
  logic [CW-1:0]     cnt;
  // Shared accumulator. Multiply: {hi, lo/multiplier}. Divide: {rem, quotient/dividend}.
  logic [2*XLEN-1:0] acc, acc_step;
  logic              accept;

  // ---------------------------------------------------------------- FSM
  assign accept = start && !kill && (state == IDLE || state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SETUP;
      SETUP:   state_nxt = CALC;
      CALC:    if (cnt == '0) state_nxt = DONE;
      DONE:    state_nxt = accept ? SETUP : IDLE;
      default: state_nxt = IDLE;
    endcase
    if (kill) state_nxt = IDLE;
  end

  assign busy  = (state == SETUP) || (state == CALC);
  assign done  = (state == DONE);
  assign wb_en = done && (rd_out != 5'd0);

  // ---------------------------------------------------------------- setup decode
  logic            a_sgn, b_sgn, sa, sb, div0, ovf;
  logic [XLEN-1:0] ma, mb;

  always_comb begin
    a_sgn = op_q inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    b_sgn = op_q inside {OP_MULH, OP_DIV, OP_REM};
    sa    = a_sgn && a_q[XLEN-1];
    sb    = b_sgn && b_q[XLEN-1];
    div0  = (b_q == '0);
    ovf   = (op_q inside {OP_DIV, OP_REM}) && (a_q == OVF_Q) && (b_q == '1);
  end

  mdu_negate #(.W(XLEN)) u_mag_a (.en(sa), .a(a_q), .y(ma));
  mdu_negate #(.W(XLEN)) u_mag_b (.en(sb), .a(b_q), .y(mb));

  // ---------------------------------------------------------------- iteration step
  logic [XLEN-1:0] mul_add;
  logic [XLEN:0]   mul_sum, rem_sh, rem_diff;

  always_comb begin
    mul_add  = acc[0] ? ma_q : '0;
    mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, mul_add};
    // Remainder shifted left with the next dividend bit: XLEN+1 bits wide.
    rem_sh   = acc[2*XLEN-1:XLEN-1];
    rem_diff = rem_sh - {1'b0, mb_q};
    acc_step = {mul_sum, acc[XLEN-1:1]};
    if (op_is_div(op_q)) begin
      // Restored remainder is always < divisor, so it fits XLEN bits.
      if (!rem_diff[XLEN]) acc_step = {rem_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
      else                 acc_step = {rem_sh[XLEN-1:0],   acc[XLEN-2:0], 1'b0};
    end
  end

  // ---------------------------------------------------------------- sign fix / select
  // Evaluated on the final step so result is registered on entry to DONE.
  logic [2*XLEN-1:0] prod_f;
  logic [XLEN-1:0]   quo_f, rem_f, res_fin;

  mdu_negate #(.W(2*XLEN)) u_fix_p (.en(sa_q ^ sb_q), .a(acc_step),                .y(prod_f));
  mdu_negate #(.W(XLEN))   u_fix_q (.en(sa_q ^ sb_q), .a(acc_step[XLEN-1:0]),      .y(quo_f));
  mdu_negate #(.W(XLEN))   u_fix_r (.en(sa_q),        .a(acc_step[2*XLEN-1:XLEN]), .y(rem_f));

  always_comb begin
    res_fin = '0;
    case (op_q)
      OP_MUL:                      res_fin = prod_f[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: res_fin = prod_f[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:             res_fin = div0_q ? DIV0_Q : (ovf_q ? OVF_Q : quo_f);
      OP_REM, OP_REMU:             res_fin = div0_q ? a_q    : (ovf_q ? '0    : rem_f);
      default:                     res_fin = '0;
    endcase
  end

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q   <= OP_MUL;
      a_q    <= '0;
      b_q    <= '0;
      rd_q   <= '0;
      ma_q   <= '0;
      mb_q   <= '0;
      sa_q   <= 1'b0;
      sb_q   <= 1'b0;
      div0_q <= 1'b0;
      ovf_q  <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      rd_out <= '0;
      result <= '0;
    end else begin
      if (accept) begin
        op_q <= mdu_op_e'(funct3);
        a_q  <= op_a;
        b_q  <= op_b;
        rd_q <= rd_in;
      end
      case (state)
        SETUP: begin
          sa_q   <= sa;
          sb_q   <= sb;
          ma_q   <= ma;
          mb_q   <= mb;
          div0_q <= div0;
          ovf_q  <= ovf;
          cnt    <= CW'(XLEN-1);
          // Divide shifts the dividend out of the low half; multiply shifts the multiplier.
          acc    <= op_is_div(op_q) ? {{XLEN{1'b0}}, ma} : {{XLEN{1'b0}}, mb};
        end
        CALC: begin
          acc <= acc_step;
          cnt <= cnt - CW'(1);
          // Outputs only move on a completion that is not being flushed.
          if (cnt == '0 && !kill) begin
            result <= res_fin;
            rd_out <= rd_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_iterative.sv
module tb_mdu_iterative;

  logic        clk = 1'b0;
  logic        rst_n, start, kill;
  logic [2:0]  funct3;
  logic [31:0] op_a, op_b;
  logic [4:0]  rd_in;
  logic        busy, done, wb_en;
  logic [4:0]  rd_out;
  logic [31:0] result;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mdu_iterative #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .kill(kill), .funct3(funct3),
    .op_a(op_a), .op_b(op_b), .rd_in(rd_in), .busy(busy), .done(done),
    .wb_en(wb_en), .rd_out(rd_out), .result(result)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge. Issues one request, scrambles the inputs afterwards,
  // optionally pulses start (while busy) or kill at a given cycle, and returns
  // at the negedge where done is seen (lat) or after a 60-cycle bound.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input int pulse_cyc, input int kill_cyc,
                        output int lat, output logic busy_c1);
    funct3 = f; op_a = a; op_b = b; rd_in = rd; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; funct3 = 3'b011; op_a = 32'hDEAD_BEEF; op_b = 32'h0BAD_F00D; rd_in = 5'd17;
    lat = 1;
    busy_c1 = busy;
    while (done !== 1'b1 && lat < 60) begin
      if (lat == pulse_cyc) begin
        start = 1'b1; funct3 = 3'b011; op_a = 32'hFFFF_FFFF; op_b = 32'hFFFF_FFFF; rd_in = 5'd30;
      end
      if (lat == kill_cyc) kill = 1'b1;
      @(negedge clk);
      lat++;
      start = 1'b0;
      kill  = 1'b0;
    end
  endtask

  task automatic do_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp,
                       input int pulse_cyc);
    int   lat;
    logic b1;
    run_op(f, a, b, rd, pulse_cyc, 0, lat, b1);
    chk({tag, "_busy1"}, {31'd0, b1}, 32'd1);
    chk({tag, "_lat"}, lat, 32'd34);
    chk({tag, "_res"}, result, exp);
    chk({tag, "_rd"}, {27'd0, rd_out}, {27'd0, rd});
    chk({tag, "_wb"}, {31'd0, wb_en}, {31'd0, rd != 5'd0});
    chk({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int   lat;
    logic b1;
    logic seen;
    rst_n = 1'b0; start = 1'b0; kill = 1'b0; funct3 = 3'b000;
    op_a = '0; op_b = '0; rd_in = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_wb", {31'd0, wb_en}, 32'd0);
    chk("rst_rd", {27'd0, rd_out}, 32'd0);
    chk("rst_res", result, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset mid-CALC
    funct3 = 3'b000; op_a = 32'd3; op_b = 32'd5; rd_in = 5'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    chk("midcalc_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_res", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
    chk("arst_nodone", {31'd0, seen}, 32'd0);
    chk("arst_busy2", {31'd0, busy}, 32'd0);
    chk("arst_res2", result, 32'd0);
    chk("arst_rd2", {27'd0, rd_out}, 32'd0);

    // Back-to-back chain: each request issued in the DONE cycle of the previous one
    do_op("mul",     3'b000, 32'd7,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 0);
    do_op("mulh",    3'b001, 32'h8000_0000,  32'hFFFF_FFFF, 5'd1,  32'h0000_0000, 0);
    do_op("mulhsu",  3'b010, 32'h8000_0000,  32'hFFFF_FFFF, 5'd2,  32'h8000_0000, 0);
    do_op("mulhu",   3'b011, 32'h8000_0000,  32'hFFFF_FFFF, 5'd3,  32'h7FFF_FFFF, 0);
    do_op("div",     3'b100, 32'hFFFF_FFF9,  32'd2,         5'd4,  32'hFFFF_FFFD, 0);
    do_op("rem",     3'b110, 32'hFFFF_FFF9,  32'd2,         5'd4,  32'hFFFF_FFFF, 0);
    do_op("divu0",   3'b101, 32'd100,        32'd0,         5'd6,  32'hFFFF_FFFF, 0);
    do_op("remu0",   3'b111, 32'd100,        32'd0,         5'd6,  32'd100,       0);
    do_op("div_ovf", 3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 5'd8,  32'h8000_0000, 0);
    do_op("rem_ovf", 3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 5'd0,  32'h0000_0000, 0);
    do_op("divu_sb", 3'b101, 32'd100,        32'd7,         5'd10, 32'd14,        5);

    // Kill at cycle 10 of a DIV with start pulsed while busy
    run_op(3'b100, 32'd1000, 32'd3, 5'd12, 5, 10, lat, b1);
    chk("kill_busy1", {31'd0, b1}, 32'd1);
    chk("kill_nodone", {31'd0, done}, 32'd0);
    chk("kill_timeout", lat, 32'd60);
    chk("kill_busy", {31'd0, busy}, 32'd0);
    chk("kill_wb", {31'd0, wb_en}, 32'd0);
    chk("kill_res", result, 32'd14);
    chk("kill_rd", {27'd0, rd_out}, 32'd10);

    // Recovery, again back-to-back
    do_op("remu",    3'b111, 32'd100,        32'd7,         5'd11, 32'd2,         0);
    do_op("divu",    3'b101, 32'hFFFF_FFFF,  32'd16,        5'd31, 32'h0FFF_FFFF, 0);
    do_op("mul2",    3'b000, 32'h1234_5678,  32'd16,        5'd9,  32'h2345_6780, 0);

    // done is a single-cycle pulse
    @(negedge clk);
    chk("done_pulse", {31'd0, done}, 32'd0);
    chk("wb_pulse", {31'd0, wb_en}, 32'd0);
    chk("hold_res", result, 32'h2345_6780);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
